oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Bus-initiator counterpart to `mem`: drives `mem`'s address/read side as a master instead of being driven by a bench.
- Implements the NES sprite DMA. On `start`, copies `XFER_LEN` bytes from CPU page `{page, 8'h00}` into OAM beginning at `oam_base`.
- Holds `halt` high while active so the CPU core is stalled.
- Sits between the CPU-side memory map (`mem`) and the PPU OAM write port.

Parameters:
- `ADDR_WIDTH`, 16, CPU address width; equals `ADDR_WIDTH` from `pkg.v`.
- `DATA_WIDTH`, 8, data width; equals `REG_WIDTH` from `pkg.v`.
- `XFER_LEN`, 256, bytes per transfer; 1..256 legal.

Ports:
- `clk`  in  1  system clock (phi0 domain); all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; CPU write to $4014.
- `page`  in  8  source page; captured on the `start` cycle.
- `cpu_odd`  in  1  high when the `start` cycle is an odd CPU cycle; captured with `start`.
- `oam_base`  in  8  OAM start index; captured with `start`.
- `src_addr`  out  ADDR_WIDTH  address to `mem`.
- `src_we`  out  1  write enable to `mem`; constant 0.
- `src_din`  in  DATA_WIDTH  `mem` `dout`; valid 1 cycle after `src_addr`.
- `oam_addr`  out  8  OAM write index.
- `oam_wdata`  out  DATA_WIDTH  OAM write data.
- `oam_we`  out  1  OAM write strobe, one cycle per byte.
- `halt`  out  1  CPU stall request.
- `done`  out  1  one-cycle pulse after the last OAM write.

Behaviour:
- Reset values:
  - `src_addr` = 0, `src_we` = 0.
  - `oam_addr` = 0, `oam_wdata` = 0, `oam_we` = 0.
  - `halt` = 0, `done` = 0.
  - State = IDLE; byte counter = 0.
  - Reset mid-transfer aborts immediately. No further OAM writes; `done` is not pulsed.
- States: IDLE, DUMMY, ALIGN, READ, WRITE.
- IDLE:
  - On `start`, latch `page`, `cpu_odd`, `oam_base`; counter = 0; go to DUMMY.
  - `halt` goes high the cycle after `start`.
- DUMMY: one cycle. Next state is ALIGN if the latched `cpu_odd` = 1, else READ.
- ALIGN: one cycle, then READ.
- READ:
  - `src_addr` = `{page_q, counter[7:0]}`, registered.
  - `oam_we` = 0.
  - Next state WRITE.
- WRITE:
  - `oam_wdata` = `src_din` (sampled this cycle, 1-cycle read latency).
  - `oam_addr` = `(oam_base_q + counter) mod 256`, wrapping 8-bit.
  - `oam_we` = 1.
  - Counter increments.
  - If counter was `XFER_LEN-1`, go to IDLE and pulse `done`; otherwise go to READ.
- `halt`:
  - High in DUMMY/ALIGN/READ/WRITE.
  - Drops the cycle after the final WRITE, coincident with `done`.
- Total halt cycles = 1 + `cpu_odd` + 2·`XFER_LEN`, i.e. 513/514 for 256 bytes.
- Source address never crosses a page: `counter[7:0]` only; the upper byte is fixed at `page_q`.
- `start` while not IDLE is ignored; latched values are unchanged.
- `start` coincident with `reset`: reset wins.
- `page` = $FF is legal; source is $FF00–$FFFF.
- `src_we` is never asserted; the block only reads `mem`.

Optional Feature:
- Macro: `OAM_DMA_CYCLE_COUNT_EN`.
- When defined:
  - Adds output port `cycle_count` [9:0]. It increments every cycle `halt` = 1, clears on accepted `start`, and holds after `done`. Reset value 0.
  - Adds a sim-only `$fatal` if `start` arrives while busy.
- When undefined: no such port, no counter logic, no checks.

Test Plan:
1. `mem` preloaded so `mem[$0200+i] = i^8'hA5`; `start` with `page=$02`, `oam_base=0`, `cpu_odd=0` -> 256 `oam_we` pulses, `oam_addr` 0..255, data `i^$A5`, `halt` high for 513 cycles, one `done`.
2. Same with `cpu_odd=1` -> identical data; `halt` high for 514 cycles; first READ one cycle later.
3. `oam_base=$F0`, `page=$03` -> byte 0 to OAM $F0, byte 16 to OAM $00 (wrap), byte 255 to OAM $EF.
4. `reset` asserted at the 100th halt cycle -> next cycle all outputs 0, no further `oam_we`, no `done`. A following `start` runs a complete 513-cycle transfer.
5. Second `start` pulsed 50 cycles into a transfer with `page=$07` -> ignored; all source addresses stay in the original page; single `done`.
6. `page=$FF`, `XFER_LEN=4` build -> reads $FF00–$FF03, 4 writes, `halt` 9 cycles. With `OAM_DMA_CYCLE_COUNT_EN`, `cycle_count` = 9 after `done`.

Source files
------------

// File: rtl/oam_dma_if.sv
// Bus bundle for oam_dma: the read side toward the CPU memory map and the OAM write port.
// The DMA engine takes the master modport; memory and OAM models take the slave modport.
interface oam_dma_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] src_addr;
  logic                  src_we;
  logic [DATA_WIDTH-1:0] src_din;
  logic [7:0]            oam_addr;
  logic [DATA_WIDTH-1:0] oam_wdata;
  logic                  oam_we;

  modport master (
    output src_addr, src_we, oam_addr, oam_wdata, oam_we,
    input  src_din
  );

  modport slave (
    input  src_addr, src_we, oam_addr, oam_wdata, oam_we,
    output src_din
  );
endinterface

// File: rtl/oam_dma.sv
// NES sprite DMA: copies XFER_LEN bytes from CPU page {page,00} into OAM at oam_base while halting the CPU.
// Optional build macro OAM_DMA_CYCLE_COUNT_EN adds a cycle_count output and a busy-start sim check.
module oam_dma #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int XFER_LEN   = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] page,
  input  logic       cpu_odd,
  input  logic [7:0] oam_base,
  output logic       halt,
  output logic       done,
`ifdef OAM_DMA_CYCLE_COUNT_EN
  output logic [9:0] cycle_count,
`endif
  oam_dma_if.master  bus
);
  typedef enum logic [2:0] {IDLE, DUMMY, ALIGN, READ, WRITE} state_t;

  localparam logic [8:0] LAST = 9'(XFER_LEN - 1);

  state_t     state_reg;
  logic [8:0] count_reg;
  logic [7:0] page_reg;
  logic [7:0] base_reg;
  logic       odd_reg;

  assign bus.src_we = 1'b0;

  // src_addr is loaded on entry to READ so mem's registered dout is ready during WRITE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      page_reg      <= '0;
      base_reg      <= '0;
      odd_reg       <= 1'b0;
      halt          <= 1'b0;
      done          <= 1'b0;
      bus.src_addr  <= '0;
      bus.oam_addr  <= '0;
      bus.oam_wdata <= '0;
      bus.oam_we    <= 1'b0;
    end else begin
      bus.oam_we <= 1'b0;
      done       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            page_reg  <= page;
            odd_reg   <= cpu_odd;
            base_reg  <= oam_base;
            count_reg <= '0;
            halt      <= 1'b1;
            state_reg <= DUMMY;
          end
        end
        DUMMY: begin
          if (odd_reg) begin
            state_reg <= ALIGN;
          end else begin
            state_reg    <= READ;
            bus.src_addr <= ADDR_WIDTH'({page_reg, count_reg[7:0]});
          end
        end
        ALIGN: begin
          state_reg    <= READ;
          bus.src_addr <= ADDR_WIDTH'({page_reg, count_reg[7:0]});
        end
        READ: begin
          state_reg <= WRITE;
        end
        WRITE: begin
          bus.oam_wdata <= bus.src_din;
          bus.oam_addr  <= base_reg + count_reg[7:0];
          bus.oam_we    <= 1'b1;
          count_reg     <= count_reg + 9'd1;
          if (count_reg == LAST) begin
            state_reg <= IDLE;
            halt      <= 1'b0;
            done      <= 1'b1;
          end else begin
            state_reg    <= READ;
            bus.src_addr <= ADDR_WIDTH'({page_reg, count_reg[7:0] + 8'd1});
          end
        end
        default: begin
          state_reg <= IDLE;
          halt      <= 1'b0;
        end
      endcase
    end
  end

`ifdef OAM_DMA_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (state_reg == IDLE && start) begin
      cycle_count <= '0;
    end else if (halt) begin
      cycle_count <= cycle_count + 10'd1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && start && state_reg != IDLE) begin
      $fatal(1, "oam_dma: start received while a transfer is in progress");
    end
  end
`endif
`endif
endmodule

// File: tb/tb_oam_dma.sv
// Randomized self-checking bench for oam_dma against a transfer-level reference model.
// Each transfer is checked for write order, OAM index wrap, data, page confinement and halt length.
module tb_oam_dma;
  localparam int XFER = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] page;
  logic       cpu_odd;
  logic [7:0] oam_base;
  logic       halt;
  logic       done;
`ifdef OAM_DMA_CYCLE_COUNT_EN
  logic [9:0] cycle_count;
`endif

  oam_dma_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  oam_dma #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .XFER_LEN(XFER)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .page       (page),
    .cpu_odd    (cpu_odd),
    .oam_base   (oam_base),
    .halt       (halt),
    .done       (done),
`ifdef OAM_DMA_CYCLE_COUNT_EN
    .cycle_count(cycle_count),
`endif
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  // CPU memory model with one cycle of read latency.
  logic [7:0] mem [0:65535];
  always @(posedge clk) bus.src_din <= mem[bus.src_addr];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_page(input logic [7:0] pg, input bit pattern);
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      a = {pg, 8'(i)};
      mem[a] = pattern ? (8'(i) ^ 8'hA5) : 8'($urandom);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_halt"}, halt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_oam_we"}, bus.oam_we, 0);
    chk({tag, "_src_addr"}, bus.src_addr, 0);
    chk({tag, "_oam_addr"}, bus.oam_addr, 0);
    chk({tag, "_oam_wdata"}, bus.oam_wdata, 0);
    chk({tag, "_src_we"}, bus.src_we, 0);
  endtask

  // One transfer: expected writes are byte k -> OAM (base+k) mod 256 with data mem[{pg,k}],
  // and halt is high for 1 + odd + 2*XFER cycles.
  task automatic run_xfer(input logic [7:0] pg, input logic [7:0] base, input logic odd,
                          input int abort_at, input bit inject);
    int k        = 0;
    int halt_cnt = 0;
    int done_cnt = 0;
    bit fin      = 0;
    bit stray    = 0;
    @(negedge clk);
    page = pg; oam_base = base; cpu_odd = odd; start = 1'b1;
    for (int cyc = 0; cyc < 2 * XFER + 20 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0; page = 8'($urandom); oam_base = 8'($urandom); cpu_odd = 1'($urandom);
      if (bus.oam_we) begin
        logic [15:0] a;
        a = {pg, 8'(k)};
        chk("oam_addr", bus.oam_addr, 32'(8'(base + 8'(k))));
        chk("oam_wdata", bus.oam_wdata, mem[a]);
        chk("src_page", bus.src_addr[15:8], pg);
        k++;
      end
      if (halt) halt_cnt++;
      chk("src_we", bus.src_we, 0);
      if (done) begin
        done_cnt++;
        fin = 1;
        chk("halt_at_done", halt, 0);
      end
      if (inject && halt_cnt == 50) begin
        start = 1'b1;
        page  = 8'h07;
      end
      if (abort_at > 0 && halt_cnt == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_outputs_zero("abort");
        repeat (20) begin
          @(negedge clk);
          if (bus.oam_we || done || halt) stray = 1;
        end
        chk("abort_quiet", stray, 0);
        $display("xfer page=%02h base=%02h odd=%0d aborted after %0d halt cycles, %0d writes",
                 pg, base, odd, halt_cnt, k);
        return;
      end
    end
    chk("done_seen", fin, 1);
    chk("write_count", k, XFER);
    chk("halt_cycles", halt_cnt, 1 + int'(odd) + 2 * XFER);
`ifdef OAM_DMA_CYCLE_COUNT_EN
    chk("cycle_count", cycle_count, 1 + int'(odd) + 2 * XFER);
`endif
    @(negedge clk);
    chk("done_single", done, 0);
    chk("halt_idle", halt, 0);
`ifdef OAM_DMA_CYCLE_COUNT_EN
    chk("cycle_count_hold", cycle_count, 1 + int'(odd) + 2 * XFER);
`endif
    $display("xfer page=%02h base=%02h odd=%0d writes=%0d halt=%0d done=%0d",
             pg, base, odd, k, halt_cnt, done_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; page = 8'h00; cpu_odd = 1'b0; oam_base = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    start = 1'b1; page = 8'h02;
    @(negedge clk);
    start = 1'b0;
    chk_outputs_zero("reset");
`ifdef OAM_DMA_CYCLE_COUNT_EN
    chk("reset_cycle_count", cycle_count, 0);
`endif
    reset = 1'b0;

    fill_page(8'h02, 1'b1);
    run_xfer(8'h02, 8'h00, 1'b0, 0, 1'b0);
    run_xfer(8'h02, 8'h00, 1'b1, 0, 1'b0);

    fill_page(8'h03, 1'b0);
    run_xfer(8'h03, 8'hF0, 1'b0, 0, 1'b0);

    fill_page(8'h04, 1'b0);
    run_xfer(8'h04, 8'h10, 1'b0, 100, 1'b0);
    run_xfer(8'h04, 8'h10, 1'b0, 0, 1'b0);

`ifndef OAM_DMA_CYCLE_COUNT_EN
    fill_page(8'h05, 1'b0);
    fill_page(8'h07, 1'b0);
    run_xfer(8'h05, 8'h80, 1'b0, 0, 1'b1);
`endif

    fill_page(8'hFF, 1'b0);
    run_xfer(8'hFF, 8'h00, 1'b1, 0, 1'b0);

    for (int t = 0; t < 3; t++) begin
      logic [7:0] pg;
      pg = 8'($urandom);
      fill_page(pg, 1'b0);
      run_xfer(pg, 8'($urandom), 1'($urandom), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
